// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with x0 hard-wire, trigger mirror and written mask.
// Optional same-cycle write forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int TRIG_IDX = 5,
    parameter int A0_IDX   = 10,
    parameter int AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic [XLEN-1:0]     trigger,
    output logic [XLEN-1:0]     a0,
    output logic [NREG-1:0]     written
);

    localparam logic [AW:0]   NREG_L = NREG[AW:0];
    localparam logic [AW-1:0] TRIG_A = TRIG_IDX[AW-1:0];
    localparam logic [NREG-1:0] ONE  = {{(NREG-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] sync1;
    logic            c0;
    logic            c1;
    logic [NREG-1:0] hit0;
    logic [NREG-1:0] hit1;

    // A write commits only to an in-range, non-zero, non-mirror register.
    assign c0 = we0 && !rst && wa0 != '0 && wa0 != TRIG_A
                && {1'b0, wa0} < NREG_L;
    assign c1 = we1 && !rst && wa1 != '0 && wa1 != TRIG_A
                && {1'b0, wa1} < NREG_L;

    assign hit0 = c0 ? (ONE << wa0) : '0;
    assign hit1 = c1 ? (ONE << wa1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            written <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            sync1   <= trigger;
            written <= written | hit0 | hit1;
            for (int i = 1; i < NREG; i++) begin
                if (TRIG_IDX != 0 && i == TRIG_IDX) begin
                    regs[i] <= sync1;
                end else if (hit1[i]) begin
                    regs[i] <= wd1;
                end else if (hit0[i]) begin
                    regs[i] <= wd0;
                end
            end
        end
    end

    assign a0 = regs[A0_IDX];

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          ok;
        assign a  = ra[k*AW +: AW];
        assign ok = a != '0 && {1'b0, a} < NREG_L;
`ifdef REGFILE_BYPASS_EN
        // W1 is checked first so it wins a same-address collision.
        assign rd[k*XLEN +: XLEN] = !ok ? '0 :
                                    (c1 && wa1 == a) ? wd1 :
                                    (c0 && wa0 == a) ? wd0 :
                                    regs[a];
`else
        assign rd[k*XLEN +: XLEN] = ok ? regs[a] : '0;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a behavioural model.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
    localparam int TRIG = 5;
    localparam int A0I  = 10;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic                we0, we1;
    logic [AW-1:0]       wa0, wa1;
    logic [XLEN-1:0]     wd0, wd1;
    logic [XLEN-1:0]     trigger;
    logic [XLEN-1:0]     a0;
    logic [NREG-1:0]     written;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    logic [XLEN-1:0] m [NREG];
    logic [XLEN-1:0] msync;
    logic [NREG-1:0] mw;

    regfile_mp dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .trigger(trigger), .a0(a0), .written(written)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit wok(logic [AW-1:0] a);
        return int'(a) != 0 && int'(a) < NREG && int'(a) != TRIG;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(logic [AW-1:0] a);
        if (int'(a) == 0 || int'(a) >= NREG) return '0;
        if (BYP && !rst && we1 && wok(wa1) && wa1 == a) return wd1;
        if (BYP && !rst && we0 && wok(wa0) && wa0 == a) return wd0;
        return m[a];
    endfunction

    // Model: register contents, written mask, trigger sampled two edges back.
    always @(posedge clk) begin
        if (rst) begin
            foreach (m[i]) m[i] = '0;
            msync = '0;
            mw    = '0;
        end else begin
            if (we0 && wok(wa0)) begin m[wa0] = wd0; mw[wa0] = 1'b1; end
            if (we1 && wok(wa1)) begin m[wa1] = wd1; mw[wa1] = 1'b1; end
            m[TRIG] = msync;
            msync   = trigger;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < NRD; k++)
                check($sformatf("rd%0d", k), rd[k*XLEN +: XLEN],
                      exp_rd(ra[k*AW +: AW]));
            check("a0", a0, m[A0I]);
            check("written", written, mw);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ra = '0; trigger = '0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        step();
        run = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_rd", rd, 64'h0);
        check("reset_a0", a0, 64'h0);
        check("reset_written", written, 64'h0);

        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
        step();
        idle(); ra = {5'd0, 5'd3};
        @(negedge clk);
        check("basic_rd0", rd[31:0], 64'hDEADBEEF);
        check("basic_written3", written[3], 64'h1);

        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h1234;
        step();
        idle(); ra = {5'd5, 5'd0};
        @(negedge clk);
        check("x0_rd", rd[31:0], 64'h0);
        check("mirror_wr_dropped", rd[63:32], 64'h0);
        check("mask_after_drops", written, 64'h8);
        trigger = 32'hA5;
        step();
        @(negedge clk);
        check("trig_one_edge", rd[63:32], 64'h0);
        step();
        @(negedge clk);
        check("trig_two_edges", rd[63:32], 64'hA5);

        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7;
        wd0 = 32'h1; wd1 = 32'h2;
        step();
        wa0 = 5'd8; wa1 = 5'd9; wd0 = 32'h88; wd1 = 32'h99;
        step();
        idle(); ra = {5'd8, 5'd7};
        @(negedge clk);
        check("collision_w1_wins", rd[31:0], 64'h2);
        check("dual_w0", rd[63:32], 64'h88);
        check("dual_mask", written, 64'h388);
        ra = {5'd9, 5'd0};
        #1;
        check("dual_w1", rd[63:32], 64'h99);

        ra = {5'd10, 5'd0};
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h55;
        #1;
        check("bypass_rd1", rd[63:32], BYP ? 64'h55 : 64'h0);
        check("a0_not_bypassed", a0, 64'h0);
        step();
        idle();
        @(negedge clk);
        check("a0_next_cycle", a0, 64'h55);

        rst = 1'b1; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h9;
        step();
        rst = 1'b0; idle(); ra = {5'd10, 5'd4};
        @(negedge clk);
        check("rst_mid_write_rd", rd[31:0], 64'h0);
        check("rst_mid_write_mask", written, 64'h0);
        check("rst_mid_write_a0", a0, 64'h0);

        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            we0 = $urandom_range(0, 1);
            we1 = $urandom_range(0, 1);
            wa0 = AW'($urandom_range(0, NREG - 1));
            wa1 = $urandom_range(0, 3) == 0 ? wa0
                                            : AW'($urandom_range(0, NREG - 1));
            wd0 = $urandom;
            wd1 = $urandom;
            if ($urandom_range(0, 3) == 0) trigger = $urandom;
            ra[AW-1:0]  = $urandom_range(0, 1) ? wa0
                                               : AW'($urandom_range(0, NREG - 1));
            ra[2*AW-1:AW] = $urandom_range(0, 1) ? wa1
                                                 : AW'($urandom_range(0, NREG - 1));
            step();
        end

        idle(); rst = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
